// File: rtl/rsa_seq_ctrl_pkg.sv
// Shared definitions for the RSA sequencer slice: FSM state type, status
// byte bit positions and the default operand width.
// Package: rsa_pkg (no ports).
package rsa_pkg;

  localparam int unsigned REG_W_DEF = 8;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_TMO  = 2;
  localparam int unsigned ST_OVR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_e;

endpackage

// File: rtl/rsa_seq_ctrl_timeout_cnt.sv
// rsa_timeout_cnt: generic WIDTH-bit up-counter with synchronous clear and
// count enable. expire_o flags the enabled cycle on which the count reaches
// all-ones, so a guard expires after exactly 2**WIDTH-1 enabled cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear (priority over en_i)
//   en_i        count enable
//   expire_o    high on the enabled cycle that brings the count to all-ones
module rsa_timeout_cnt #(
  parameter int unsigned WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: sequencer between the SPI register file and the rsa_unit
// modular-exponentiation core. Snapshots operands on start, enables the core
// for one operation, captures C on eoc, strobes the result once and keeps a
// sticky status byte. A RUN timeout guards against a hung core.
// Optional feature macro: RSA_SEQ_CTRL_IRQ_EN adds irq_mask_i / irq_o.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_i, abort_i            1-cycle action pulses
//   status_clr_i                1-cycle pulse, clears sticky status bits
//   p_i, e_i, m_i, const_i      live register values
//   rsa_en_o                    core enable (also its run/clear)
//   rsa_p_o..rsa_const_o        frozen operands
//   rsa_eoc_i, rsa_c_i          core end-of-conversion and result
//   result_o, result_vld_o      captured C and its 1-cycle write strobe
//   status_o                    {4'b0, overrun, timeout, busy, done}
//   irq_mask_i, irq_o           (RSA_SEQ_CTRL_IRQ_EN only) interrupt
module rsa_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned REG_W     = REG_W_DEF,
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             status_clr_i,
  input  logic [REG_W-1:0] p_i,
  input  logic [REG_W-1:0] e_i,
  input  logic [REG_W-1:0] m_i,
  input  logic [REG_W-1:0] const_i,
  output logic             rsa_en_o,
  output logic [REG_W-1:0] rsa_p_o,
  output logic [REG_W-1:0] rsa_e_o,
  output logic [REG_W-1:0] rsa_m_o,
  output logic [REG_W-1:0] rsa_const_o,
  input  logic             rsa_eoc_i,
  input  logic [REG_W-1:0] rsa_c_i,
  output logic [REG_W-1:0] result_o,
  output logic             result_vld_o,
  output logic [7:0]       status_o
`ifdef RSA_SEQ_CTRL_IRQ_EN
  ,
  input  logic [1:0]       irq_mask_i,
  output logic             irq_o
`endif
);

  state_e state_q, state_d;
  logic   done_q, done_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic   busy, start_ok, launch, capture, tmo_set, ovr_set, expire;

  rsa_timeout_cnt #(.WIDTH(TIMEOUT_W)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != RUN),
    .en_i     (state_q == RUN),
    .expire_o (expire)
  );

  assign busy = (state_q != IDLE);
  // A coincident abort always drops the start, whatever the state.
  assign start_ok = start_i & ~abort_i;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE: if (start_ok) begin
        state_d = LOAD;
        launch  = 1'b1;
      end
      LOAD: state_d = abort_i ? IDLE : RUN;
      RUN: begin
        // Priority: abort, then eoc, then timeout expiry.
        if (abort_i) begin
          state_d = IDLE;
        end else if (rsa_eoc_i) begin
          state_d = CAPT;
          capture = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end
      end
      CAPT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ovr_set = start_ok & busy;

    // Set events take priority over clears landing in the same cycle.
    done_d = done_q;
    if (capture)                    done_d = 1'b1;
    else if (launch | status_clr_i) done_d = 1'b0;

    tmo_d = tmo_q;
    if (tmo_set)                    tmo_d = 1'b1;
    else if (launch | status_clr_i) tmo_d = 1'b0;

    ovr_d = ovr_q;
    if (ovr_set)           ovr_d = 1'b1;
    else if (status_clr_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
      rsa_p_o     <= '0;
      rsa_e_o     <= '0;
      rsa_m_o     <= '0;
      rsa_const_o <= '0;
      result_o    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      if (launch) begin
        rsa_p_o     <= p_i;
        rsa_e_o     <= e_i;
        rsa_m_o     <= m_i;
        rsa_const_o <= const_i;
      end
      if (capture) result_o <= rsa_c_i;
    end
  end

  assign rsa_en_o     = (state_q == RUN);
  assign result_vld_o = (state_q == CAPT);

  always_comb begin
    status_o          = '0;
    status_o[ST_DONE] = done_q;
    status_o[ST_BUSY] = busy;
    status_o[ST_TMO]  = tmo_q;
    status_o[ST_OVR]  = ovr_q;
  end

`ifdef RSA_SEQ_CTRL_IRQ_EN
  logic irq_q;

  // Built from next-state sticky bits so irq_o tracks status_o cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= (done_d & irq_mask_i[0]) | (tmo_d & irq_mask_i[1]);
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
module tb_rsa_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, abort_i, status_clr_i;
  logic [7:0] p_i, e_i, m_i, const_i;
  logic       rsa_en_o, rsa_eoc_i, result_vld_o;
  logic [7:0] rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o, rsa_c_i, result_o, status_o;

  logic       start2_i;
  logic       en2, vld2;
  logic [7:0] p2, e2, m2, k2, res2, status2;

`ifdef RSA_SEQ_CTRL_IRQ_EN
  logic irq_o, irq2;
`endif

  int errors = 0;
  int checks = 0;
  int n_lat  = 20;
  int strobes2 = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  rsa_seq_ctrl #(.REG_W(8), .TIMEOUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .status_clr_i(status_clr_i), .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
    .rsa_en_o(rsa_en_o), .rsa_p_o(rsa_p_o), .rsa_e_o(rsa_e_o), .rsa_m_o(rsa_m_o),
    .rsa_const_o(rsa_const_o), .rsa_eoc_i(rsa_eoc_i), .rsa_c_i(rsa_c_i),
    .result_o(result_o), .result_vld_o(result_vld_o), .status_o(status_o)
`ifdef RSA_SEQ_CTRL_IRQ_EN
    , .irq_mask_i(2'b01), .irq_o(irq_o)
`endif
  );

  // Second instance with a short timeout and a core that never finishes.
  rsa_seq_ctrl #(.REG_W(8), .TIMEOUT_W(4)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .start_i(start2_i), .abort_i(1'b0),
    .status_clr_i(1'b0), .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
    .rsa_en_o(en2), .rsa_p_o(p2), .rsa_e_o(e2), .rsa_m_o(m2),
    .rsa_const_o(k2), .rsa_eoc_i(1'b0), .rsa_c_i(8'h00),
    .result_o(res2), .result_vld_o(vld2), .status_o(status2)
`ifdef RSA_SEQ_CTRL_IRQ_EN
    , .irq_mask_i(2'b10), .irq_o(irq2)
`endif
  );

  function automatic logic [7:0] modexp(input logic [7:0] p, input logic [7:0] e,
                                        input logic [7:0] m);
    int r;
    if (p == 0) return 8'h00;
    r = 1 % int'(p);
    for (int i = 0; i < int'(e); i++) r = (r * int'(m)) % int'(p);
    return r[7:0];
  endfunction

  // Behavioural rsa_unit: eoc n_lat cycles after en rises, C = M^E mod P.
  int stub_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt  <= 0;
      rsa_eoc_i <= 1'b0;
      rsa_c_i   <= 8'h00;
    end else if (!rsa_en_o) begin
      stub_cnt  <= 0;
      rsa_eoc_i <= 1'b0;
    end else begin
      stub_cnt  <= stub_cnt + 1;
      rsa_eoc_i <= (stub_cnt == n_lat - 1);
      rsa_c_i   <= modexp(rsa_p_o, rsa_e_o, rsa_m_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result scoreboard: every strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && result_vld_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got result_vld_o=1 result=0x%0h expected no strobe", result_o);
      end else begin
        check("result", {24'h0, result_o}, {24'h0, sb.pop_front()});
        check("done_with_vld", {31'h0, status_o[0]}, 32'h1);
      end
    end
    if (rst_n && vld2) strobes2++;
  end

  typedef struct {
    logic [7:0] p, e, m, k;
    int         n;
    logic [7:0] exp_c;
  } vec_t;
  vec_t vecs[5];

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!status_o[1]) break;
      @(negedge clk);
    end
    if (i == 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after 300 cycles expected idle", name);
    end
  endtask

  task automatic set_ops(input vec_t v);
    p_i = v.p; e_i = v.e; m_i = v.m; const_i = v.k; n_lat = v.n;
  endtask

  task automatic run_vec(input vec_t v);
    set_ops(v);
    sb.push_back(v.exp_c);
    pulse_start();
    check("en_load", {31'h0, rsa_en_o}, 32'h0);
    check("status_load", {24'h0, status_o}, 32'h02);
    @(negedge clk);
    check("en_run", {31'h0, rsa_en_o}, 32'h1);
    check("op_p", {24'h0, rsa_p_o}, {24'h0, v.p});
    check("op_e", {24'h0, rsa_e_o}, {24'h0, v.e});
    check("op_m", {24'h0, rsa_m_o}, {24'h0, v.m});
    check("op_const", {24'h0, rsa_const_o}, {24'h0, v.k});
    wait_idle("run");
    check("status_done", {24'h0, status_o}, 32'h01);
    check("sb_drained", sb.size(), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    vecs[0] = '{p:8'd33,  e:8'd7, m:8'd4,   k:8'h5A, n:20, exp_c:8'd16};
    vecs[1] = '{p:8'd13,  e:8'd3, m:8'd5,   k:8'h01, n:3,  exp_c:8'd8};
    vecs[2] = '{p:8'd255, e:8'd1, m:8'd200, k:8'hFF, n:1,  exp_c:8'd200};
    vecs[3] = '{p:8'd251, e:8'd2, m:8'd250, k:8'h00, n:7,  exp_c:8'd1};
    vecs[4] = '{p:8'd7,   e:8'd0, m:8'd3,   k:8'hC3, n:5,  exp_c:8'd1};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; status_clr_i = 1'b0; start2_i = 1'b0;
    p_i = 8'h11; e_i = 8'h22; m_i = 8'h33; const_i = 8'h44;
    repeat (2) @(negedge clk);
    check("rst_en", {31'h0, rsa_en_o}, 32'h0);
    check("rst_vld", {31'h0, result_vld_o}, 32'h0);
    check("rst_status", {24'h0, status_o}, 32'h0);
    check("rst_result", {24'h0, result_o}, 32'h0);
    check("rst_op_m", {24'h0, rsa_m_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
`ifdef RSA_SEQ_CTRL_IRQ_EN
      check("irq_done", {31'h0, irq_o}, 32'h1);
`endif
    end

    // Start while busy sets overrun; status_clr clears everything.
    set_ops(vecs[1]);
    n_lat = 10;
    sb.push_back(vecs[1].exp_c);
    pulse_start();
    @(negedge clk);
    pulse_start();
    check("status_ovr_run", {24'h0, status_o}, 32'h0A);
    wait_idle("ovr");
    check("status_ovr_done", {24'h0, status_o}, 32'h09);
    status_clr_i = 1'b1;
    @(negedge clk);
    status_clr_i = 1'b0;
    check("status_clr", {24'h0, status_o}, 32'h00);
`ifdef RSA_SEQ_CTRL_IRQ_EN
    check("irq_clr", {31'h0, irq_o}, 32'h0);
`endif

    // Abort in RUN cycle 5: no strobe, done stays clear.
    set_ops(vecs[0]);
    pulse_start();
    @(negedge clk);
    check("abort_en_run", {31'h0, rsa_en_o}, 32'h1);
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_en", {31'h0, rsa_en_o}, 32'h0);
    check("abort_status", {24'h0, status_o}, 32'h00);
    repeat (30) @(negedge clk);
    check("abort_no_strobe", sb.size(), 32'h0);
    run_vec(vecs[0]);

    // Operands stay frozen while live registers change.
    set_ops(vecs[0]);
    sb.push_back(vecs[0].exp_c);
    pulse_start();
    @(negedge clk);
    m_i = 8'hFF;
    repeat (3) @(negedge clk);
    check("frozen_m", {24'h0, rsa_m_o}, 32'h04);
    wait_idle("frozen");
    check("frozen_status", {24'h0, status_o}, 32'h01);
    check("frozen_sb", sb.size(), 32'h0);

    // Timeout on the short-timeout instance: exactly 15 RUN cycles.
    start2_i = 1'b1;
    @(negedge clk);
    start2_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (en2) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    check("tmo_cycles", cnt, 32'd15);
    check("tmo_status", {24'h0, status2}, 32'h04);
    check("tmo_en", {31'h0, en2}, 32'h0);
    repeat (3) @(negedge clk);
    check("tmo_no_strobe", strobes2, 32'h0);
`ifdef RSA_SEQ_CTRL_IRQ_EN
    check("irq_tmo", {31'h0, irq2}, 32'h1);
`endif

    // Asynchronous reset mid-RUN clears outputs immediately.
    set_ops(vecs[1]);
    n_lat = 40;
    pulse_start();
    repeat (4) @(negedge clk);
    check("pre_rst_en", {31'h0, rsa_en_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_en", {31'h0, rsa_en_o}, 32'h0);
    check("arst_vld", {31'h0, result_vld_o}, 32'h0);
    check("arst_status", {24'h0, status_o}, 32'h0);
    check("arst_result", {24'h0, result_o}, 32'h0);
    check("arst_op_p", {24'h0, rsa_p_o}, 32'h0);
    check("arst_op_const", {24'h0, rsa_const_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("arst_no_strobe", sb.size(), 32'h0);
    check("arst_idle", {24'h0, status_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
